pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed MEM/WB latch.
- A generic pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer, so in_ready is fully registered and there is no combinational ready path.
- Synchronous flush squashes all held entries.
- The payload carries a sideband of write-enable bits. These are forced to 0 whenever the stage is invalid or squashed, so a bubble can never write architectural state.
- Instantiated between any two pipeline stages, initially MEM->WB.

Parameters:
- DATA_W, 64: width of the general payload bus, for example wd, wdata, hi, lo, cp0 address and data, packed by the instantiating stage.
- WEN_W, 4: number of write-enable sideband bits, for example wreg, whilo, LLbit_we, cp0_we.
- RST_DATA, 0: value of out_data at reset, on flush, and while invalid.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of every entry held in the stage.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry; registered.
- in_data  in  DATA_W  upstream payload.
- in_wen  in  WEN_W  upstream write enables.
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload to downstream.
- out_wen  out  WEN_W  write enables to downstream, gated by out_valid.
- occupancy  out  2  number of entries held, 0 to 2.

Behaviour:
- Handshakes
  - Input transfer (acc) = in_valid & in_ready.
  - Output transfer (drn) = out_valid & out_ready.
  - Payload and wen are captured only on acc.
- Storage
  - Main register: main_v, main_d, main_w. This drives the outputs.
  - Skid register: skid_v, skid_d, skid_w.
- Priority: rst > flush > normal operation.
- Reset (rst=1 at a clk edge)
  - main_v = skid_v = 0; out_valid = 0; in_ready = 1.
  - out_data = RST_DATA; out_wen = 0; occupancy = 0.
- Flush (flush=1, rst=0)
  - Identical register results to reset.
  - An input offered in the same cycle is dropped (acc is ignored).
  - An entry presented with out_ready=1 in the flush cycle counts as consumed downstream. Downstream owns squash of that entry.
- Combinational outputs
  - out_valid = main_v.
  - out_data = main_v ? main_d : RST_DATA.
  - out_wen = main_v ? main_w : 0.
  - occupancy = main_v + skid_v.
- State machine: EMPTY (0 entries), ONE (main only), FULL (main and skid).
  - EMPTY, acc: load main -> ONE. Latency is 1 cycle from in to out.
  - EMPTY, no acc: stay EMPTY.
  - ONE, acc & drn: load main with the new entry -> ONE. Sustains 1 transfer per cycle.
  - ONE, acc & ~drn: load skid -> FULL; in_ready goes 0 next cycle.
  - ONE, ~acc & drn: -> EMPTY.
  - ONE, no acc, no drn: hold.
  - FULL, drn: main takes skid -> ONE; in_ready goes 1 next cycle.
  - FULL, ~drn: hold.
  - FULL, acc: impossible, because in_ready=0.
- in_ready is registered and equals ~skid_v of the next state. It is 1 in EMPTY and ONE, 0 in FULL.
- in_data and in_wen are don't-care when in_valid=0; they must never reach the outputs.
- Ordering is strictly FIFO and entries are never duplicated.
- Reset or flush during FULL drops both entries.
- The 2-bit occupancy cannot wrap; its maximum value is 2.

Optional Feature:
- Macro PIPE_STAGE_STAT_EN.
- When defined, adds two outputs:
  - stall_cnt, 32 bits: counts cycles with out_valid & ~out_ready.
  - bubble_cnt, 32 bits: counts cycles with ~out_valid & out_ready.
- Both counters saturate at 32'hFFFF_FFFF.
- Both are cleared by rst only. Flush does not clear them, and a flush cycle is counted per the pre-flush out_valid.
- When not defined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
1. Reset then stream: hold out_ready=1 and drive 4 back-to-back entries in_data=1,2,3,4, in_wen=4'hF -> out_data=1,2,3,4 on consecutive cycles starting 1 cycle after acceptance; in_ready stays 1; occupancy=1 throughout.
2. Backpressure: with out_ready=0, send entries A=0x11 then B=0x22 -> occupancy=2, in_ready=0 the cycle after B, out_data=0x11 held. Raise out_ready -> 0x11 then 0x22 delivered, with in_ready=1 one cycle after the first drain.
3. Flush in FULL: with 2 entries held and in_valid=1, in_data=0x33, pulse flush -> next cycle out_valid=0, out_wen=0, out_data=RST_DATA, occupancy=0, and 0x33 never appears.
4. Bubble gating: send in_valid=0 with in_wen=4'hF and in_data=0xDEAD -> out_wen stays 0 and out_valid stays 0.
5. Reset mid-stream: assert rst while FULL and while flush=1 -> all outputs are at reset values the next cycle; operation resumes normally once rst deasserts.
6. With PIPE_STAGE_STAT_EN: hold 3 cycles of out_valid=1, out_ready=0, then 2 idle cycles with out_ready=1 -> stall_cnt=3, bubble_cnt=2. Pulse flush -> counters unchanged.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Purpose: generic pipeline-stage register with valid/ready handshake and 2-entry skid buffer; in_ready is registered.
// Latency: 1 cycle from acceptance to out_valid; sustains one transfer per cycle while downstream is ready.
// Backpressure: the skid entry absorbs the transfer in flight when out_ready drops; in_ready falls one cycle later.
// Optional build macro PIPE_STAGE_STAT_EN adds saturating stall_cnt / bubble_cnt outputs.
module pipe_stage_skid #(
  parameter int                 DATA_W   = 64,
  parameter int                 WEN_W    = 4,
  parameter logic [DATA_W-1:0]  RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [WEN_W-1:0]  in_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [WEN_W-1:0]  out_wen,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STAT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                in_ready_q;
  logic [DATA_W-1:0]   main_d, skid_d;
  logic [WEN_W-1:0]    main_w, skid_w;
  logic                main_v, skid_v;
  logic                acc, drn;
  logic                ld_main_in, ld_main_skid, ld_skid;

  // Entry-valid flags fall straight out of the state encoding.
  assign main_v = (state_q != EMPTY);
  assign skid_v = (state_q == FULL);

  assign acc = in_valid & in_ready_q;
  assign drn = main_v & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = main_v;
  // Payload and write enables are masked whenever the stage holds nothing, so a bubble never writes state.
  assign out_data  = main_v ? main_d : RST_DATA;
  assign out_wen   = main_v ? main_w : '0;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  // Next-state and register-load selection; FULL never sees acc because in_ready is low there.
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          ld_main_in = 1'b1;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (acc && drn) begin
          ld_main_in = 1'b1;
        end else if (acc) begin
          ld_skid = 1'b1;
          state_d = FULL;
        end else if (drn) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drn) begin
          ld_main_skid = 1'b1;
          state_d      = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State and registered ready; reset and flush both empty the stage and drop any same-cycle input.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Payload storage; main is refilled from input or from skid, skid only captures while main is stalled.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_d <= RST_DATA;
      main_w <= '0;
      skid_d <= RST_DATA;
      skid_w <= '0;
    end else begin
      if (ld_main_in) begin
        main_d <= in_data;
        main_w <= in_wen;
      end else if (ld_main_skid) begin
        main_d <= skid_d;
        main_w <= skid_w;
      end
      if (ld_skid) begin
        skid_d <= in_data;
        skid_w <= in_wen;
      end
    end
  end

`ifdef PIPE_STAGE_STAT_EN
  // Saturating stall/bubble counters; only rst clears them, a flush cycle counts on the pre-flush out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_v && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (!main_v && out_ready && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, backpressure, flush, bubble gating, reset, optional counters.
module tb_pipe_stage_skid;

  localparam int               DATA_W = 64;
  localparam int               WEN_W  = 4;
  localparam logic [63:0]      RSTV   = 64'hA5A5_0000_0000_5A5A;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [WEN_W-1:0]  in_wen;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [WEN_W-1:0]  out_wen;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_STAT_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       bubble_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W  (DATA_W),
    .WEN_W   (WEN_W),
    .RST_DATA(RSTV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_wen   (in_wen),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_wen  (out_wen),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_STAT_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, ".out_wen"},   {60'd0, out_wen},   64'd0);
    chk({tag, ".out_data"},  out_data,           RSTV);
    chk({tag, ".occupancy"}, {62'd0, occupancy}, 64'd0);
    chk({tag, ".in_ready"},  {63'd0, in_ready},  64'd1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_wen = '0;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;

    // 1: back-to-back stream with out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 64'(i);
      in_wen  = 4'hF;
      tick();
      chk("stream.data", out_data, 64'(i));
      chk("stream.wen",  {60'd0, out_wen}, 64'hF);
      chk("stream.occ",  {62'd0, occupancy}, 64'd1);
      chk("stream.rdy",  {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk_idle("stream_end");

    // 2: backpressure fills skid, then drains in order
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 64'h11; in_wen = 4'h3;
    tick();
    chk("bp.a_data", out_data, 64'h11);
    chk("bp.a_rdy",  {63'd0, in_ready}, 64'd1);
    in_data = 64'h22; in_wen = 4'h5;
    tick();
    chk("bp.full_occ",  {62'd0, occupancy}, 64'd2);
    chk("bp.full_rdy",  {63'd0, in_ready}, 64'd0);
    chk("bp.full_data", out_data, 64'h11);
    in_data = 64'h99; in_wen = 4'hF;
    tick();
    chk("bp.hold_occ",  {62'd0, occupancy}, 64'd2);
    chk("bp.hold_data", out_data, 64'h11);
    chk("bp.hold_wen",  {60'd0, out_wen}, 64'h3);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp.b_data", out_data, 64'h22);
    chk("bp.b_wen",  {60'd0, out_wen}, 64'h5);
    chk("bp.b_rdy",  {63'd0, in_ready}, 64'd1);
    chk("bp.b_occ",  {62'd0, occupancy}, 64'd1);
    tick();
    chk_idle("bp_end");

    // 3: flush while FULL with a concurrent input offer
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 64'h44; in_wen = 4'hF;
    tick();
    in_data = 64'h55;
    tick();
    chk("fl.pre_occ", {62'd0, occupancy}, 64'd2);
    in_data = 64'h33; flush = 1'b1;
    tick();
    chk_idle("flush");
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk_idle("flush_after");

    // 4: invalid input with live-looking payload must not leak
    in_valid = 1'b0; in_data = 64'hDEAD; in_wen = 4'hF;
    tick();
    chk_idle("bubble1");
    tick();
    chk_idle("bubble2");

    // 5: reset together with flush while FULL, then resume
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 64'h66; in_wen = 4'h1;
    tick();
    in_data = 64'h77;
    tick();
    chk("rst.pre_occ", {62'd0, occupancy}, 64'd2);
    rst = 1'b1; flush = 1'b1; in_data = 64'h88;
    tick();
    chk_idle("midrst");
    rst = 1'b0; flush = 1'b0;
    in_data = 64'h99; in_wen = 4'h2; out_ready = 1'b1;
    tick();
    chk("resume.data", out_data, 64'h99);
    chk("resume.wen",  {60'd0, out_wen}, 64'h2);
    chk("resume.occ",  {62'd0, occupancy}, 64'd1);
    in_valid = 1'b0;
    tick();
    chk_idle("resume_end");

`ifdef PIPE_STAGE_STAT_EN
    // 6: stall and bubble counters, unaffected by flush
    rst = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("stat.rst_stall",  {32'd0, stall_cnt},  64'd0);
    chk("stat.rst_bubble", {32'd0, bubble_cnt}, 64'd0);
    in_valid = 1'b1; in_data = 64'h1; in_wen = 4'hF;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("stat.stall3", {32'd0, stall_cnt}, 64'd3);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("stat.stall",  {32'd0, stall_cnt},  64'd3);
    chk("stat.bubble", {32'd0, bubble_cnt}, 64'd2);
    out_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("stat.fl_stall",  {32'd0, stall_cnt},  64'd3);
    chk("stat.fl_bubble", {32'd0, bubble_cnt}, 64'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
